// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
//   Host-side sequencer for the configuration scan chain. A request word is
//   shifted into the chain MSB first. At the same time the previous chain
//   contents are captured from scan_out and returned as the response word.
//   This lets software write a configuration and read back the old value in
//   a single transaction.
//
// Parameters
//   N      chain length in bits (must match the attached scan_chain)
//   CNT_W  shift counter width, derived from N (leave at default)
//
// Ports
//   scan_clk        clock shared with the scan chain
//   scan_rstb       asynchronous active-low reset, shared with the chain
//   req_valid/ready request handshake; req_data is the word to load
//   rsp_valid/ready response handshake; rsp_data is the previous contents
//   chain_scan_en   scan enable to the chain (registered)
//   chain_scan_in   serial data to the chain (registered, wr_sr MSB)
//   chain_scan_out  serial data from the chain
//   busy            high whenever the controller is not idle
module scan_chain_ctrl #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic         scan_clk,
  input  logic         scan_rstb,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         chain_scan_en,
  output logic         chain_scan_in,
  input  logic         chain_scan_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       wr_sr;
  logic [N-1:0]       rd_sr;
  logic               scan_en_q;
  logic               rsp_valid_q;
  logic [N-1:0]       rsp_data_q;

  // The chain's scan_out flop lags its shift register by one edge. So the
  // first SHIFT edge has nothing new to capture. The final bit arrives
  // during FLUSH, one edge after the last shift.
  always_ff @(posedge scan_clk or negedge scan_rstb) begin
    if (!scan_rstb) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_sr       <= '0;
      rd_sr       <= '0;
      scan_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_sr     <= req_data;
            cnt       <= '0;
            scan_en_q <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          wr_sr <= {wr_sr[N-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          if (cnt != '0) begin
            rd_sr <= {rd_sr[N-2:0], chain_scan_out};
          end
          if (cnt == LAST_CNT) begin
            scan_en_q <= 1'b0;
            state     <= FLUSH;
          end
        end
        FLUSH: begin
          rd_sr       <= {rd_sr[N-2:0], chain_scan_out};
          rsp_data_q  <= {rd_sr[N-2:0], chain_scan_out};
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign chain_scan_en = scan_en_q;
  assign chain_scan_in = wr_sr[N-1];
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;

  logic        clk = 1'b0;
  logic        rst8 = 1'b0, rst64 = 1'b0;
  logic        rv8 = 1'b0, rv64 = 1'b0, rs8 = 1'b0, rs64 = 1'b0;
  logic [63:0] req_data = '0;
  logic        rdy8, rdy64, val8, val64, en8, en64, si8, si64, so8, so64, busy8, busy64;
  logic [7:0]  rd8, dout8;
  logic [63:0] rd64, dout64;

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;  // 0 selects the N=8 build, 1 the N=64 build
  logic [63:0] model [2];  // current chain contents as seen by software

  always #5 clk = ~clk;

  scan_chain_ctrl #(.N(8)) d8 (
    .scan_clk(clk), .scan_rstb(rst8), .req_valid(rv8), .req_ready(rdy8),
    .req_data(req_data[7:0]), .rsp_valid(val8), .rsp_ready(rs8), .rsp_data(rd8),
    .chain_scan_en(en8), .chain_scan_in(si8), .chain_scan_out(so8), .busy(busy8)
  );

  scan_chain_ctrl #(.N(64)) d64 (
    .scan_clk(clk), .scan_rstb(rst64), .req_valid(rv64), .req_ready(rdy64),
    .req_data(req_data), .rsp_valid(val64), .rsp_ready(rs64), .rsp_data(rd64),
    .chain_scan_en(en64), .chain_scan_in(si64), .chain_scan_out(so64), .busy(busy64)
  );

  // Attached scan chains
  always_ff @(posedge clk or negedge rst8) begin
    if (!rst8) begin
      dout8 <= '0; so8 <= 1'b0;
    end else if (en8) begin
      so8 <= dout8[7]; dout8 <= {dout8[6:0], si8};
    end
  end

  always_ff @(posedge clk or negedge rst64) begin
    if (!rst64) begin
      dout64 <= '0; so64 <= 1'b0;
    end else if (en64) begin
      so64 <= dout64[63]; dout64 <= {dout64[62:0], si64};
    end
  end

  // Views of the selected build
  logic        v_ready, v_valid, v_en, v_busy;
  logic [63:0] v_rsp, v_dout;
  always_comb begin
    v_ready = sel ? rdy64  : rdy8;
    v_valid = sel ? val64  : val8;
    v_en    = sel ? en64   : en8;
    v_busy  = sel ? busy64 : busy8;
    v_rsp   = sel ? rd64   : {56'd0, rd8};
    v_dout  = sel ? dout64 : {56'd0, dout8};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_rv(input logic v);
    rv8  = v & ~sel;
    rv64 = v & sel;
  endtask

  task automatic drive_rs(input logic v);
    rs8  = v & ~sel;
    rs64 = v & sel;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst8 = 1'b0; rst64 = 1'b0;
    rv8 = 1'b0; rv64 = 1'b0; rs8 = 1'b0; rs64 = 1'b0;
    repeat (2) @(negedge clk);
    rst8 = 1'b1; rst64 = 1'b1;
    model[0] = '0; model[1] = '0;
  endtask

  // One full write/readback transaction on the selected build. During the
  // hold cycles, the response is back-pressured while a competing request
  // is presented.
  task automatic txn(input logic [63:0] wr, input logic [63:0] exp, input int hold);
    int nb;
    int en_cyc;
    int lat;
    bit seen;
    logic [63:0] mask;
    nb   = sel ? 64 : 8;
    mask = sel ? '1 : 64'hFF;
    @(negedge clk);
    drive_rv(1'b1);
    req_data = wr;
    for (int i = 0; i < 50 && !v_ready; i++) @(negedge clk);
    if (!v_ready) begin
      check("req_ready_timeout", {63'd0, v_ready}, 64'd1);
      drive_rv(1'b0);
      return;
    end
    @(negedge clk);
    drive_rv(1'b0);
    en_cyc = 0; lat = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (v_en) en_cyc++;
      if (v_valid) begin
        seen = 1'b1; lat = i;
        break;
      end
      @(negedge clk);
    end
    check("rsp_valid_seen", {63'd0, seen}, 64'd1);
    if (!seen) return;
    check("latency", 64'(lat), 64'(nb + 1));
    check("scan_en_cycles", 64'(en_cyc), 64'(nb));
    check("rsp_data", v_rsp, exp & mask);
    check("chain_dout", v_dout, wr & mask);
    for (int h = 0; h < hold; h++) begin
      drive_rv(1'b1);
      req_data = ~wr;
      @(negedge clk);
      check("hold_rsp_valid", {63'd0, v_valid}, 64'd1);
      check("hold_rsp_data", v_rsp, exp & mask);
      check("hold_scan_en", {63'd0, v_en}, 64'd0);
      check("hold_req_ready", {63'd0, v_ready}, 64'd0);
      check("hold_dout", v_dout, wr & mask);
    end
    drive_rv(1'b0);
    req_data = wr;
    drive_rs(1'b1);
    @(negedge clk);
    drive_rs(1'b0);
    check("post_rsp_valid", {63'd0, v_valid}, 64'd0);
    check("post_busy", {63'd0, v_busy}, 64'd0);
    check("post_req_ready", {63'd0, v_ready}, 64'd1);
    if (hold > 0) check("post_dout", v_dout, wr & mask);
  endtask

  typedef struct {
    bit          sel;
    logic [63:0] wr;
    logic [63:0] exp_rsp;
    int          hold;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 64'hA5,                  64'h00,                  0};
    vecs[1] = '{1'b0, 64'h3C,                  64'hA5,                  10};
    vecs[2] = '{1'b1, 64'hDEAD_BEEF_0123_4567, 64'h0,                   0};
    vecs[3] = '{1'b1, 64'h0,                   64'hDEAD_BEEF_0123_4567, 0};
    vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   3};
    vecs[5] = '{1'b0, 64'h00,                  64'h3C,                  0};
    vecs[6] = '{1'b1, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 0};

    do_reset();
    @(negedge clk);
    check("rst_ready8",   {63'd0, rdy8},  64'd1);
    check("rst_ready64",  {63'd0, rdy64}, 64'd1);
    check("rst_busy8",    {63'd0, busy8}, 64'd0);
    check("rst_busy64",   {63'd0, busy64}, 64'd0);
    check("rst_en8",      {62'd0, en8, si8}, 64'd0);
    check("rst_en64",     {62'd0, en64, si64}, 64'd0);
    check("rst_valid",    {62'd0, val8, val64}, 64'd0);
    check("rst_rsp8",     {56'd0, rd8}, 64'd0);
    check("rst_rsp64",    rd64, 64'd0);

    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].sel;
      txn(vecs[v].wr, vecs[v].exp_rsp, vecs[v].hold);
    end
    model[0] = 64'h00;
    model[1] = 64'h8000_0000_0000_0001;

    // Reset in the middle of shifting
    do_reset();
    sel = 1'b0;
    @(negedge clk);
    rv8 = 1'b1; req_data = 64'hFF;
    @(negedge clk);
    rv8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_busy_before", {63'd0, busy8}, 64'd1);
    rst8 = 1'b0;
    #1;
    check("midrst_en",    {63'd0, en8},   64'd0);
    check("midrst_si",    {63'd0, si8},   64'd0);
    check("midrst_valid", {63'd0, val8},  64'd0);
    check("midrst_rsp",   {56'd0, rd8},   64'd0);
    check("midrst_busy",  {63'd0, busy8}, 64'd0);
    check("midrst_dout",  {56'd0, dout8}, 64'd0);
    repeat (2) @(negedge clk);
    rst8 = 1'b1;
    begin
      bit any_valid;
      any_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (val8) any_valid = 1'b1;
      end
      check("midrst_no_rsp", {63'd0, any_valid}, 64'd0);
    end
    txn(64'h81, 64'h00, 0);
    model[0] = 64'h81;

    // Back-to-back with req_valid and rsp_ready held high
    do_reset();
    sel = 1'b0;
    begin
      logic [7:0] wdat [3];
      int acc_t [$];
      logic [7:0] rsps [$];
      logic pb;
      int t;
      int idx;
      wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h04;
      pb = 1'b0; t = 0; idx = 0;
      @(negedge clk);
      rs8 = 1'b1; rv8 = 1'b1; req_data = 64'h01;
      for (int c = 0; c < 80 && rsps.size() < 3; c++) begin
        @(negedge clk);
        t++;
        if (busy8 && !pb) begin
          acc_t.push_back(t);
          idx++;
          if (idx < 3) req_data = {56'd0, wdat[idx]};
          else rv8 = 1'b0;
        end
        if (val8) rsps.push_back(rd8);
        pb = busy8;
      end
      rv8 = 1'b0;
      check("b2b_accepts", 64'(acc_t.size()), 64'd3);
      check("b2b_responses", 64'(rsps.size()), 64'd3);
      if (acc_t.size() == 3) begin
        check("b2b_spacing1", 64'(acc_t[1] - acc_t[0]), 64'd11);
        check("b2b_spacing2", 64'(acc_t[2] - acc_t[1]), 64'd11);
      end
      if (rsps.size() == 3) begin
        check("b2b_rsp0", {56'd0, rsps[0]}, 64'h00);
        check("b2b_rsp1", {56'd0, rsps[1]}, 64'h01);
        check("b2b_rsp2", {56'd0, rsps[2]}, 64'h02);
      end
      repeat (3) @(negedge clk);
      rs8 = 1'b0;
      check("b2b_dout", {56'd0, dout8}, 64'h04);
      model[0] = 64'h04;
    end

    // Randomized transactions on both builds against the software-view model
    for (int r = 0; r < 24; r++) begin
      logic [63:0] wr;
      sel = 1'($urandom_range(0, 1));
      wr  = {$urandom(), $urandom()};
      if (!sel) wr = wr & 64'hFF;
      txn(wr, model[sel], int'($urandom_range(0, 3)));
      model[sel] = wr;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Host-side sequencer for the configuration scan chain.
- Accepts an N-bit write word over a valid/ready request port and serially shifts it into the chain, MSB first, using scan_en/scan_in.
- Simultaneously captures the chain's previous contents from scan_out.
- Returns the captured word over a valid/ready response port, so software can write configuration and read back the old value in one transaction.

Parameters:
- N, 64, chain length in bits; must match the attached scan_chain.
- CNT_W, $clog2(N+1), shift counter width (derived; do not override).

Ports:
- scan_clk  input  1  clock shared with the scan chain
- scan_rstb  input  1  asynchronous active-low reset, shared with the scan chain
- req_valid  input  1  host request valid
- req_ready  output  1  controller can accept a request
- req_data  input  N  word to load into the chain
- rsp_valid  output  1  readback word valid
- rsp_ready  input  1  host accepts readback
- rsp_data  output  N  previous chain contents; rsp_data[N-1] is the old chain dout[N-1]
- chain_scan_en  output  1  to scan_chain scan_en
- chain_scan_in  output  1  to scan_chain scan_in
- chain_scan_out  input  1  from scan_chain scan_out
- busy  output  1  high in any state other than IDLE

Behaviour:
- Chain model:
  - On each posedge with scan_en=1: dout <= {dout[N-2:0], scan_in}.
  - scan_out is a separate flop loaded with pre-edge dout[N-1].
  - So after shift edge k, scan_out = old dout[N-k].
- Outputs that must come directly from flops: chain_scan_en, chain_scan_in (= wr_sr[N-1]), rsp_valid, rsp_data. No combinational path from req_* to chain_*.
- Reset (scan_rstb=0, async):
  - state=IDLE, cnt=0, wr_sr=0, rd_sr=0.
  - chain_scan_en=0, chain_scan_in=0, rsp_valid=0, rsp_data=0, busy=0.
  - req_ready=1 once reset deasserts.
- FSM states: IDLE, SHIFT, FLUSH, RESP.
- IDLE:
  - req_ready=1.
  - On edge E0 with req_valid: wr_sr<=req_data, cnt<=0, chain_scan_en<=1, go to SHIFT.
- SHIFT (chain_scan_en=1, req_ready=0):
  - Each edge: wr_sr<={wr_sr[N-2:0],1'b0}, cnt<=cnt+1.
  - If cnt!=0, rd_sr<={rd_sr[N-2:0], chain_scan_out}.
  - At the edge where cnt==N-1 (the Nth shift edge E_N): chain_scan_en<=0, go to FLUSH.
  - Exactly N chain shifts per transaction, at E1..E_N.
- FLUSH (chain_scan_en=0):
  - One cycle.
  - rd_sr captures the final bit.
  - rsp_data<={rd_sr[N-2:0], chain_scan_out}, rsp_valid<=1, go to RESP.
- RESP:
  - Hold rsp_valid and rsp_data stable until rsp_ready.
  - On the handshake edge: rsp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle; req_ready is 0 in RESP.
- Latency:
  - Request accept at E0, rsp_valid high after E_{N+1}, i.e. N+1 cycles.
  - Minimum request-to-request spacing is N+3 cycles with rsp_ready held high.
- After the transaction, chain dout == req_data, and it is held because scan_en=0 outside SHIFT.
- The chain is touched only in SHIFT. req_valid in non-IDLE states is ignored; the host must hold it and req_data until req_ready.
- rsp_ready outside RESP: no effect.
- Reset mid-transaction:
  - Immediately IDLE with all outputs at reset values.
  - The partial response is discarded; no rsp_valid.
  - The chain is also cleared by the shared scan_rstb.
- cnt never exceeds N-1 in SHIFT; no wrap-around.

Test Plan:
- Bench setup: N=8 and N=64 builds, each with a real scan_chain instance attached.
- N=8, after reset, write 0xA5 -> chain_scan_en high exactly 8 cycles, chain dout=0xA5 after FLUSH, rsp_data=0x00, rsp_valid asserted 9 cycles after accept.
- N=8, write 0xA5 then 0x3C -> second rsp_data=0xA5, chain dout=0x3C.
- N=64, write 64'hDEAD_BEEF_0123_4567 then 64'h0 -> second rsp_data=64'hDEAD_BEEF_0123_4567, dout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, chain_scan_en=0, chain dout unchanged, req_ready=0, a new req_valid is not accepted; raise rsp_ready -> IDLE the next cycle.
- Reset mid-shift: N=8, write 0xFF, assert scan_rstb=0 after 4 shift edges -> all outputs 0 immediately, dout=0, no rsp_valid; a subsequent write of 0x81 returns rsp_data=0x00 and dout=0x81.
- Back-to-back: req_valid and rsp_ready held high for 3 writes (0x01, 0x02, 0x04) -> each accepted in IDLE, spacing N+3 cycles, responses 0x00, 0x01, 0x02.
